// File: rtl/bp_be_commit_buffer.sv
// Elastic FIFO that captures backend commit events (rd write / mem write) for trace consumers.
// Optional saturating statistics counters are enabled with BP_COMMIT_BUF_STATS_EN.
module bp_be_commit_buffer #(
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int fu_op_width_p    = 6,
  parameter int els_p            = 8,
  parameter int stat_width_p     = 32,
  localparam int ptr_w           = $clog2(els_p),
  localparam int cnt_w           = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        cmt_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0] cmt_rd_addr_i,
  input  logic                        cmt_mem_w_v_i,
  input  logic [dword_width_p-1:0]    cmt_mem_addr_i,
  input  logic [fu_op_width_p-1:0]    cmt_mem_op_i,
  input  logic [dword_width_p-1:0]    cmt_data_i,
  input  logic                        clear_i,
  output logic                        v_o,
  input  logic                        ready_i,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic                        mem_w_v_o,
  output logic [dword_width_p-1:0]    mem_addr_o,
  output logic [fu_op_width_p-1:0]    mem_op_o,
  output logic [dword_width_p-1:0]    data_o,
  output logic [cnt_w-1:0]            count_o,
  output logic                        overflow_o,
  output logic [stat_width_p-1:0]     commit_cnt_o,
  output logic [stat_width_p-1:0]     drop_cnt_o,
  output logic [stat_width_p-1:0]     stall_cnt_o
);

  localparam int ent_w = 2 + reg_addr_width_p + 2 * dword_width_p + fu_op_width_p;

  typedef enum logic {e_run, e_err} state_e;

  state_e           state_reg, state_next;
  logic [ptr_w-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [cnt_w-1:0] count_reg, count_next;
  logic [ent_w-1:0] mem [els_p];
  logic [ent_w-1:0] head;
  logic             event_v, deq, enq, drop, full;

  assign event_v = cmt_rd_w_v_i | cmt_mem_w_v_i;
  assign full    = (count_reg == cnt_w'(els_p));
  assign v_o     = (count_reg != '0);
  assign deq     = v_o & ready_i;

  // Full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    state_next = state_reg;
    enq        = 1'b0;
    drop       = 1'b0;
    if (clear_i) begin
      state_next = e_run;
    end else if (event_v) begin
      if (state_reg == e_run && (!full || deq)) begin
        enq = 1'b1;
      end else begin
        drop       = 1'b1;
        state_next = e_err;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (clear_i)          count_next = '0;
    else if (enq && !deq) count_next = count_reg + 1'b1;
    else if (!enq && deq) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg  <= e_run;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (clear_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem[wr_ptr_reg] <= {cmt_rd_w_v_i, cmt_mem_w_v_i, cmt_rd_addr_i,
                          cmt_mem_addr_i, cmt_mem_op_i, cmt_data_i};
  end

  assign head = mem[rd_ptr_reg];
  assign {rd_w_v_o, mem_w_v_o, rd_addr_o, mem_addr_o, mem_op_o, data_o} = head;
  assign count_o    = count_reg;
  assign overflow_o = (state_reg == e_err);

`ifdef BP_COMMIT_BUF_STATS_EN
  logic [stat_width_p-1:0] commit_cnt_reg, drop_cnt_reg, stall_cnt_reg;

  // Counters survive clear_i so long-run drop history is not lost on a flush.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      commit_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      if (enq && commit_cnt_reg != '1)              commit_cnt_reg <= commit_cnt_reg + 1'b1;
      if (drop && drop_cnt_reg != '1)               drop_cnt_reg   <= drop_cnt_reg + 1'b1;
      if (v_o && !ready_i && stall_cnt_reg != '1)   stall_cnt_reg  <= stall_cnt_reg + 1'b1;
    end
  end

  assign commit_cnt_o = commit_cnt_reg;
  assign drop_cnt_o   = drop_cnt_reg;
  assign stall_cnt_o  = stall_cnt_reg;
`else
  assign commit_cnt_o = '0;
  assign drop_cnt_o   = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bp_be_commit_buffer.sv
// Directed self-checking bench for bp_be_commit_buffer (els_p=8, 64-bit data, 6-bit op).
`timescale 1ns/1ps
module tb_bp_be_commit_buffer;

`ifdef BP_COMMIT_BUF_STATS_EN
  localparam bit stats_on = 1'b1;
`else
  localparam bit stats_on = 1'b0;
`endif

  logic        clk, reset_n;
  logic        cmt_rd_w_v, cmt_mem_w_v, clear, ready;
  logic [4:0]  cmt_rd_addr;
  logic [63:0] cmt_mem_addr, cmt_data;
  logic [5:0]  cmt_mem_op;
  logic        v, rd_w_v, mem_w_v, overflow;
  logic [4:0]  rd_addr;
  logic [63:0] mem_addr, data;
  logic [5:0]  mem_op;
  logic [3:0]  count;
  logic [31:0] commit_cnt, drop_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rd;
    bit          mem;
    logic [4:0]  a;
    logic [63:0] ma;
    logic [5:0]  op;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  int   m_commit, m_drop, m_stall;

  bp_be_commit_buffer #(.fu_op_width_p(6)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmt_rd_w_v_i(cmt_rd_w_v), .cmt_rd_addr_i(cmt_rd_addr),
    .cmt_mem_w_v_i(cmt_mem_w_v), .cmt_mem_addr_i(cmt_mem_addr),
    .cmt_mem_op_i(cmt_mem_op), .cmt_data_i(cmt_data),
    .clear_i(clear), .v_o(v), .ready_i(ready),
    .rd_w_v_o(rd_w_v), .rd_addr_o(rd_addr), .mem_w_v_o(mem_w_v),
    .mem_addr_o(mem_addr), .mem_op_o(mem_op), .data_o(data),
    .count_o(count), .overflow_o(overflow),
    .commit_cnt_o(commit_cnt), .drop_cnt_o(drop_cnt), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t mk(input int i);
    ent_t e;
    e.rd  = (i % 3) != 1;
    e.mem = (i % 3) != 0;
    e.a   = 5'(i);
    e.ma  = 64'h8000_0000 + 64'(i) * 8;
    e.op  = 6'(i);
    e.d   = 64'hA5A5_0000_0000_0000 | 64'(i);
    return e;
  endfunction

  function automatic ent_t idle();
    ent_t e;
    e.rd = 0; e.mem = 0; e.a = '0; e.ma = '0; e.op = '0; e.d = '0;
    return e;
  endfunction

  function automatic logic [140:0] pack(input ent_t e);
    return {e.rd, e.mem, e.a, e.ma, e.op, e.d};
  endfunction

  function automatic logic [140:0] head();
    return {rd_w_v, mem_w_v, rd_addr, mem_addr, mem_op, data};
  endfunction

  // Drives one cycle of inputs, advances the reference queue, then waits past the edge.
  task automatic step(input ent_t e, input bit rdy, input bit clr);
    bit deq;
    cmt_rd_w_v = e.rd; cmt_mem_w_v = e.mem; cmt_rd_addr = e.a;
    cmt_mem_addr = e.ma; cmt_mem_op = e.op; cmt_data = e.d;
    ready = rdy; clear = clr;
    deq = (q.size() != 0) && rdy;
    if (q.size() != 0 && !rdy) m_stall++;
    if (clr) begin
      q.delete();
      m_err = 0;
    end else begin
      if (deq) void'(q.pop_front());
      if (e.rd || e.mem) begin
        if (!m_err && q.size() < 8) begin q.push_back(e); m_commit++; end
        else begin m_drop++; m_err = 1; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (v !== 1'b0) begin bad++; $display("FAIL reset_v got=%b exp=0", v); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if ({commit_cnt, drop_cnt, stall_cnt} !== 96'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", commit_cnt, drop_cnt, stall_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    ent_t e = idle();
    e.rd = 1; e.a = 5'd5; e.d = 64'hDEAD;
    step(e, 1'b1, 1'b0);
    total++; if (v !== 1'b1 || count !== 4'd1) begin
      bad++; $display("FAIL single_valid got v=%b cnt=%0d exp v=1 cnt=1", v, count); end
    total++; if (rd_w_v !== 1'b1 || mem_w_v !== 1'b0 || rd_addr !== 5'd5 || data !== 64'hDEAD) begin
      bad++; $display("FAIL single_fields got rd=%b mem=%b a=%0d d=%h exp 1 0 5 dead", rd_w_v, mem_w_v, rd_addr, data); end
    step(idle(), 1'b1, 1'b0);
    total++; if (v !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL single_drain got v=%b cnt=%0d exp 0 0", v, count); end
    $display("test_single done");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(mk(i), 1'b0, 1'b0);
    total++; if (count !== 4'd8 || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_full got cnt=%0d ovf=%b exp 8 0", count, overflow); end
    total++; if (head() !== pack(mk(0))) begin
      bad++; $display("FAIL ovf_head_stable got=%h exp=%h", head(), pack(mk(0))); end
    step(mk(8), 1'b0, 1'b0);
    total++; if (overflow !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL ovf_drop got ovf=%b cnt=%0d exp 1 8", overflow, count); end
    total++; if (drop_cnt !== (stats_on ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, stats_on ? 1 : 0); end
    step(mk(9), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++; if (v !== 1'b1 || head() !== pack(mk(i))) begin
        bad++; $display("FAIL ovf_drain[%0d] got v=%b %h exp %h", i, v, head(), pack(mk(i))); end
      step(mk(10), 1'b1, 1'b0);
    end
    total++; if (v !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_empty got v=%b cnt=%0d ovf=%b exp 0 0 1", v, count, overflow); end
    step(idle(), 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_full_bypass();
    for (int i = 0; i < 8; i++) step(mk(20 + i), 1'b0, 1'b0);
    step(mk(28), 1'b1, 1'b0);
    total++; if (count !== 4'd8 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_deq_enq got cnt=%0d ovf=%b exp 8 0", count, overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (v !== 1'b1 || head() !== pack(mk(21 + i))) begin
        bad++; $display("FAIL full_drain[%0d] got v=%b %h exp %h", i, v, head(), pack(mk(21 + i))); end
      step(idle(), 1'b1, 1'b0);
    end
    $display("test_full_bypass done");
  endtask

  task automatic test_toggle();
    int k = 0;
    for (int c = 0; c < 30; c++) begin
      if (q.size() != 0) begin
        total++; if (v !== 1'b1 || head() !== pack(q[0])) begin
          bad++; $display("FAIL toggle_head[c%0d] got v=%b %h exp %h", c, v, head(), pack(q[0])); end
      end
      if ((c % 3) != 2) begin step(mk(40 + k), c[0], 1'b0); k++; end
      else step(idle(), c[0], 1'b0);
    end
    for (int n = 0; n < 16 && q.size() != 0; n++) begin
      total++; if (v !== 1'b1 || head() !== pack(q[0])) begin
        bad++; $display("FAIL toggle_drain[%0d] got v=%b %h exp %h", n, v, head(), pack(q[0])); end
      step(idle(), 1'b1, 1'b0);
    end
    total++; if (count !== 4'd0 || overflow !== 1'b0 || k !== 20) begin
      bad++; $display("FAIL toggle_end got cnt=%0d ovf=%b ev=%0d exp 0 0 20", count, overflow, k); end
    total++; if (stall_cnt !== (stats_on ? 32'(m_stall) : 32'd0)) begin
      bad++; $display("FAIL toggle_stall got=%0d exp=%0d", stall_cnt, stats_on ? m_stall : 0); end
    total++; if (commit_cnt !== (stats_on ? 32'(m_commit) : 32'd0)) begin
      bad++; $display("FAIL toggle_commit got=%0d exp=%0d", commit_cnt, stats_on ? m_commit : 0); end
    $display("test_toggle done");
  endtask

  task automatic test_err_clear();
    for (int i = 0; i < 9; i++) step(mk(60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++; if (head() !== pack(mk(60 + i))) begin
        bad++; $display("FAIL err_drain[%0d] got %h exp %h", i, head(), pack(mk(60 + i))); end
      step(idle(), 1'b1, 1'b0);
    end
    total++; if (count !== 4'd3 || overflow !== 1'b1) begin
      bad++; $display("FAIL err_three got cnt=%0d ovf=%b exp 3 1", count, overflow); end
    step(mk(70), 1'b0, 1'b1);
    total++; if (count !== 4'd0 || v !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL err_clear got cnt=%0d v=%b ovf=%b exp 0 0 0", count, v, overflow); end
    total++; if (drop_cnt !== (stats_on ? 32'(m_drop) : 32'd0)) begin
      bad++; $display("FAIL err_clear_drops got=%0d exp=%0d", drop_cnt, stats_on ? m_drop : 0); end
    step(mk(71), 1'b0, 1'b0);
    total++; if (count !== 4'd1 || head() !== pack(mk(71))) begin
      bad++; $display("FAIL err_rerun got cnt=%0d %h exp 1 %h", count, head(), pack(mk(71))); end
    step(idle(), 1'b1, 1'b0);
    $display("test_err_clear done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(mk(80 + i), 1'b0, 1'b0);
    cmt_rd_w_v = 0; cmt_mem_w_v = 0;
    #3 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    q.delete(); m_err = 0; m_commit = 0; m_drop = 0; m_stall = 0;
    total++; if (v !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL async_reset got v=%b cnt=%0d ovf=%b exp 0 0 0", v, count, overflow); end
    total++; if ({commit_cnt, drop_cnt, stall_cnt} !== 96'd0) begin
      bad++; $display("FAIL async_reset_stats got=%0d/%0d/%0d exp=0/0/0", commit_cnt, drop_cnt, stall_cnt); end
    @(posedge clk); #1;
    step(mk(90), 1'b0, 1'b0);
    total++; if (count !== 4'd1 || head() !== pack(mk(90))) begin
      bad++; $display("FAIL async_reset_resume got cnt=%0d %h exp 1 %h", count, head(), pack(mk(90))); end
    $display("test_async_reset done");
  endtask

  initial begin
    reset_n = 1'b0; clear = 0; ready = 0;
    cmt_rd_w_v = 0; cmt_mem_w_v = 0; cmt_rd_addr = '0;
    cmt_mem_addr = '0; cmt_mem_op = '0; cmt_data = '0;
    m_err = 0; m_commit = 0; m_drop = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_full_bypass();
    test_toggle();
    test_err_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
